// File: rtl/rs_encoder_if.sv
// Handshake bundle between a message source, the RS(7,3) encoder and the codeword consumer.
// All symbols are in log-index form: 0 = zero element, k = alpha^(k-1).
interface rs_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  message;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] codeword;

    modport master (
        output in_valid,
        output message,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  codeword
    );

    modport slave (
        input  in_valid,
        input  message,
        input  out_ready,
        output in_ready,
        output out_valid,
        output codeword
    );
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(7,3) encoder over GF(8), x^3+x+1, g(x) = x^4 + a^3 x^3 + x^2 + a x + a^3.
// Serial LFSR division: one message symbol per clock, highest-order symbol first.
module rs_encoder (
    input  logic        clk,
    input  logic        reset,
    rs_encoder_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  cnt;
    logic [8:0]  msg_reg;
    logic [2:0]  r0, r1, r2, r3;
    logic [2:0]  r0_nxt, r1_nxt, r2_nxt, r3_nxt;
    logic [2:0]  d;
    logic [2:0]  f;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [20:0] codeword_q;
    logic        accept;

    // Log-index symbol to polynomial basis (bit2..bit0).
    function automatic logic [2:0] poly_of(input logic [2:0] idx);
        logic [2:0] p;
        case (idx)
            3'd1:    p = 3'b001;
            3'd2:    p = 3'b010;
            3'd3:    p = 3'b100;
            3'd4:    p = 3'b011;
            3'd5:    p = 3'b110;
            3'd6:    p = 3'b111;
            3'd7:    p = 3'b101;
            default: p = 3'b000;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] index_of(input logic [2:0] p);
        logic [2:0] idx;
        case (p)
            3'b001:  idx = 3'd1;
            3'b010:  idx = 3'd2;
            3'b100:  idx = 3'd3;
            3'b011:  idx = 3'd4;
            3'b110:  idx = 3'd5;
            3'b111:  idx = 3'd6;
            3'b101:  idx = 3'd7;
            default: idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Multiply by alpha: shift left, fold x^3 back as x+1.
    function automatic logic [2:0] mul_a(input logic [2:0] p);
        return {p[1], p[0] ^ p[2], p[2]};
    endfunction

    function automatic logic [2:0] mul_a3(input logic [2:0] p);
        return mul_a(mul_a(mul_a(p)));
    endfunction

    always_comb begin
        case (cnt)
            2'd0:    d = poly_of(msg_reg[8:6]);
            2'd1:    d = poly_of(msg_reg[5:3]);
            default: d = poly_of(msg_reg[2:0]);
        endcase
        f      = d ^ r3;
        r3_nxt = r2 ^ mul_a3(f);
        r2_nxt = r1 ^ f;
        r1_nxt = r0 ^ mul_a(f);
        r0_nxt = mul_a3(f);
    end

    // in_ready_q is only ever high in IDLE, so it doubles as the accept qualifier.
    assign accept = bus.in_valid & in_ready_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == 2'd2) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            codeword_q  <= '0;
            msg_reg     <= '0;
            cnt         <= '0;
            r0          <= '0;
            r1          <= '0;
            r2          <= '0;
            r3          <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        msg_reg <= bus.message;
                        cnt     <= '0;
                        r0      <= '0;
                        r1      <= '0;
                        r2      <= '0;
                        r3      <= '0;
                    end
                end
                SHIFT: begin
                    r0  <= r0_nxt;
                    r1  <= r1_nxt;
                    r2  <= r2_nxt;
                    r3  <= r3_nxt;
                    cnt <= cnt + 2'd1;
                    // Last division step: capture the codeword from the final remainder.
                    if (cnt == 2'd2) begin
                        codeword_q <= {msg_reg, index_of(r3_nxt), index_of(r2_nxt),
                                       index_of(r1_nxt), index_of(r0_nxt)};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.codeword  = codeword_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: hand-computed codeword table, syndrome checks on random
// messages, backpressure and mid-operation reset sequences.
module tb_rs_encoder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rs_encoder_if bus();

    rs_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [8:0]  msg;
        logic [20:0] cw;
    } vec_t;

    vec_t vecs [7];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // alpha^e in polynomial basis.
    function automatic logic [2:0] exp_poly(input int e);
        logic [2:0] p;
        case (e % 7)
            0:       p = 3'b001;
            1:       p = 3'b010;
            2:       p = 3'b100;
            3:       p = 3'b011;
            4:       p = 3'b110;
            5:       p = 3'b111;
            default: p = 3'b101;
        endcase
        return p;
    endfunction

    // Evaluate the codeword polynomial at alpha^j.
    function automatic logic [2:0] synd(input logic [20:0] cw, input int j);
        logic [2:0] s;
        logic [2:0] k;
        s = 3'b000;
        for (int i = 0; i < 7; i++) begin
            k = cw[3*i +: 3];
            if (k != 3'd0) s = s ^ exp_poly(int'(k) - 1 + i * j);
        end
        return s;
    endfunction

    // Present msg until accepted, then wait for out_valid; lat counts edges after accept.
    task automatic encode(input logic [8:0] msg, output logic [20:0] cw, output int lat);
        int t;
        bus.message  = msg;
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_wait", 32'(t < 20), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.message  = ~msg;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        cw = bus.codeword;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [20:0] cw;
        logic [8:0]  m;
        int          lat;
        bit          seen;

        vecs[0] = '{9'h000, 21'h000000};
        vecs[1] = '{9'h001, 21'h001854};
        vecs[2] = '{9'h008, 21'h00867F};
        vecs[3] = '{9'h040, 21'h040A6E};
        vecs[4] = '{9'h049, 21'h049249};
        vecs[5] = '{9'h002, 21'h002A9D};
        vecs[6] = '{9'h1FF, 21'h1FFFFF};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.message   = 9'h000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_codeword",  32'(bus.codeword),  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            encode(vecs[i].msg, cw, lat);
            chk($sformatf("cw_%0d", i), 32'(cw), 32'(vecs[i].cw));
            chk($sformatf("lat_%0d", i), 32'(lat), 32'd3);
            @(posedge clk); #1;
            chk($sformatf("ov_drop_%0d", i), 32'(bus.out_valid), 32'd0);
            chk($sformatf("ir_back_%0d", i), 32'(bus.in_ready), 32'd1);
        end

        for (int i = 0; i < 12; i++) begin
            m = 9'($urandom_range(0, 511));
            encode(m, cw, lat);
            chk($sformatf("rnd_msg_%0d", i), 32'(cw[20:12]), 32'(m));
            chk($sformatf("rnd_lat_%0d", i), 32'(lat), 32'd3);
            for (int j = 1; j <= 4; j++)
                chk($sformatf("rnd_S%0d_%0d", j, i), 32'(synd(cw, j)), 32'd0);
            @(posedge clk); #1;
        end

        // Backpressure: codeword must hold while the source keeps pushing.
        bus.out_ready = 1'b0;
        encode(9'h049, cw, lat);
        chk("bp_cw", 32'(cw), 32'h049249);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.message  = (i % 2 == 1) ? 9'h1FF : 9'h002;
            @(posedge clk); #1;
            chk($sformatf("bp_hold_%0d", i), 32'(bus.codeword), 32'h049249);
            chk($sformatf("bp_ir_%0d", i),   32'(bus.in_ready), 32'd0);
            chk($sformatf("bp_ov_%0d", i),   32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        bus.message   = 9'h041;
        @(posedge clk); #1;
        chk("bp_release_ov", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ir", 32'(bus.in_ready), 32'd1);
        encode(9'h041, cw, lat);
        chk("bp_next_cw", 32'(cw), 32'h041E1B);
        @(posedge clk); #1;

        // Reset during the second SHIFT cycle discards the pending codeword.
        bus.message  = 9'h1FF;
        bus.in_valid = 1'b1;
        chk("abort_ir", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_output", 32'(seen), 32'd0);
        encode(9'h001, cw, lat);
        chk("abort_next_cw", 32'(cw), 32'h001854);
        chk("abort_next_lat", 32'(lat), 32'd3);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
